// File: rtl/dmac_pkg.sv
// dmac_pkg: shared FSM encodings and word-size helpers for the burst scheduler
package dmac_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        ISSUE = 2'd2
    } state_t;

    localparam int BYTES_PER_WORD = 4;

    function automatic int bytes_per_word(input int w_d);
        return w_d / 8;
    endfunction
endpackage

// File: rtl/dmac_burst_scheduler_if.sv
// dmac_burst_scheduler_if: request and external address-channel signals of the burst scheduler
interface dmac_burst_scheduler_if #(
    parameter int W_EXT_A = 32,
    parameter int W_BLEN  = 9,
    parameter int W_SIZE  = 32
);
    logic               req_valid;
    logic               req_ready;
    logic               req_write;
    logic [W_EXT_A-1:0] req_addr;
    logic [W_SIZE-1:0]  req_size;
    logic               busy;
    logic               done;
    logic [W_EXT_A-1:0] ext_addr;
    logic               ext_read_enable;
    logic               ext_write_enable;
    logic [W_BLEN-1:0]  ext_word_size;
    logic               ext_ready;

    modport master (
        output req_valid, req_write, req_addr, req_size, ext_ready,
        input  req_ready, busy, done, ext_addr, ext_read_enable, ext_write_enable, ext_word_size
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_size, ext_ready,
        output req_ready, busy, done, ext_addr, ext_read_enable, ext_write_enable, ext_word_size
    );
endinterface

// File: rtl/dmac_burst_len_calc.sv
// dmac_burst_len_calc: next burst length = min(remaining, MAX_BURST_LEN, words to boundary)
module dmac_burst_len_calc
    import dmac_pkg::*;
#(
    parameter int W_D           = 32,
    parameter int W_BOUNDARY_A  = 12,
    parameter int W_BLEN        = 9,
    parameter int MAX_BURST_LEN = 256,
    parameter int W_SIZE        = 32
) (
    input  logic [W_BOUNDARY_A-1:0] i_addr,
    input  logic [W_SIZE-1:0]       i_remaining,
    output logic [W_BLEN-1:0]       o_len
);
    localparam int LOG2_BPW = $clog2(bytes_per_word(W_D));
    localparam int W_C      = 64;

    logic [W_BOUNDARY_A:0] w_bytes;
    logic [W_BOUNDARY_A:0] w_words;
    logic [W_C-1:0]        w_rem;
    logic [W_C-1:0]        w_bnd;
    logic [W_C-1:0]        w_max;
    logic [W_C-1:0]        w_m1;

    // One extra bit keeps a full 2^W_BOUNDARY_A distance (aligned address) from truncating to zero
    assign w_bytes = {1'b1, {W_BOUNDARY_A{1'b0}}} - {1'b0, i_addr};
    assign w_words = w_bytes >> LOG2_BPW;
    assign w_rem   = W_C'(i_remaining);
    assign w_bnd   = W_C'(w_words);
    assign w_max   = W_C'(MAX_BURST_LEN);
    assign w_m1    = (w_rem < w_bnd) ? w_rem : w_bnd;
    assign o_len   = W_BLEN'((w_m1 < w_max) ? w_m1 : w_max);
endmodule

// File: rtl/dmac_burst_scheduler.sv
// dmac_burst_scheduler: splits a transfer request into boundary-safe bursts on the address channel
module dmac_burst_scheduler
    import dmac_pkg::*;
#(
    parameter int W_D           = 32,
    parameter int W_EXT_A       = 32,
    parameter int W_BOUNDARY_A  = 12,
    parameter int W_BLEN        = 9,
    parameter int MAX_BURST_LEN = 256,
    parameter int W_SIZE        = 32
) (
    input logic                   CLK,
    input logic                   RST,
    dmac_burst_scheduler_if.slave bus
);
    localparam int                 LOG2_BPW = $clog2(bytes_per_word(W_D));
    localparam logic [W_EXT_A-1:0] A_MASK   = W_EXT_A'(bytes_per_word(W_D) - 1);

    state_t              r_state;
    logic [W_EXT_A-1:0]  r_addr;
    logic [W_SIZE-1:0]   r_rem;
    logic                r_write;
    logic                r_rd_en;
    logic                r_wr_en;
    logic                r_done;
    logic [W_BLEN-1:0]   r_len;
    logic [W_BLEN-1:0]   w_len;

    dmac_burst_len_calc #(
        .W_D           (W_D),
        .W_BOUNDARY_A  (W_BOUNDARY_A),
        .W_BLEN        (W_BLEN),
        .MAX_BURST_LEN (MAX_BURST_LEN),
        .W_SIZE        (W_SIZE)
    ) u_len_calc (
        .i_addr      (r_addr[W_BOUNDARY_A-1:0]),
        .i_remaining (r_rem),
        .o_len       (w_len)
    );

    // Scheduler FSM: accept request, size next burst, hold it on the channel until accepted
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_rem   <= '0;
            r_write <= 1'b0;
            r_rd_en <= 1'b0;
            r_wr_en <= 1'b0;
            r_done  <= 1'b0;
            r_len   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_addr  <= bus.req_addr & ~A_MASK;
                        r_rem   <= bus.req_size;
                        r_write <= bus.req_write;
                        if (bus.req_size == '0) r_done <= 1'b1;
                        else r_state <= CALC;
                    end
                end
                CALC: begin
                    r_len   <= w_len;
                    r_rd_en <= !r_write;
                    r_wr_en <= r_write;
                    r_state <= ISSUE;
                end
                ISSUE: begin
                    if (bus.ext_ready) begin
                        r_addr  <= r_addr + (W_EXT_A'(r_len) << LOG2_BPW);
                        r_rem   <= r_rem - W_SIZE'(r_len);
                        r_rd_en <= 1'b0;
                        r_wr_en <= 1'b0;
                        if (r_rem == W_SIZE'(r_len)) begin
                            r_state <= IDLE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= CALC;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready        = (r_state == IDLE);
    assign bus.busy             = (r_state != IDLE);
    assign bus.done             = r_done;
    assign bus.ext_addr         = r_addr;
    assign bus.ext_read_enable  = r_rd_en;
    assign bus.ext_write_enable = r_wr_en;
    assign bus.ext_word_size    = r_len;
endmodule

// File: tb/tb_dmac_burst_scheduler.sv
// tb_dmac_burst_scheduler: directed table-driven checks plus stall and reset-abort sequences
module tb_dmac_burst_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    dmac_burst_scheduler_if #(.W_EXT_A(32), .W_BLEN(9), .W_SIZE(32)) bus ();

    dmac_burst_scheduler #(
        .W_D(32), .W_EXT_A(32), .W_BOUNDARY_A(12), .W_BLEN(9), .MAX_BURST_LEN(256), .W_SIZE(32)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    typedef struct {
        logic             wr;
        logic [31:0]      addr;
        logic [31:0]      size;
        int               nb;
        logic [2:0][31:0] ea;
        logic [2:0][8:0]  el;
    } vec_t;

    vec_t vecs [7];

    function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] size, input int nb,
                                input logic [31:0] a0, input logic [8:0] l0, input logic [31:0] a1,
                                input logic [8:0] l1, input logic [31:0] a2, input logic [8:0] l2);
        vec_t v;
        v.wr = wr; v.addr = addr; v.size = size; v.nb = nb;
        v.ea[0] = a0; v.ea[1] = a1; v.ea[2] = a2;
        v.el[0] = l0; v.el[1] = l1; v.el[2] = l2;
        return v;
    endfunction

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, exp);
        end
    endtask

    task automatic wait_en(output bit ok);
        int t = 0;
        while (!(bus.ext_read_enable || bus.ext_write_enable) && t < 20) begin
            @(negedge clk);
            t++;
        end
        ok = (t < 20);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL en_timeout: got no enable within 20 cycles, expected an enable");
        end
    endtask

    task automatic send(input logic wr, input logic [31:0] addr, input logic [31:0] size);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_size  = size;
    endtask

    task automatic run_vec(input int k);
        vec_t v = vecs[k];
        bit   ok;
        @(negedge clk);
        chk($sformatf("v%0d_ready", k), 64'(bus.req_ready), 64'd1);
        send(v.wr, v.addr, v.size);
        @(negedge clk);
        bus.req_valid = 1'b0;
        if (v.nb == 0) begin
            chk($sformatf("v%0d_done0", k), 64'(bus.done), 64'd1);
            chk($sformatf("v%0d_noen", k), 64'({bus.ext_read_enable, bus.ext_write_enable}), 64'd0);
            chk($sformatf("v%0d_ready0", k), 64'(bus.req_ready), 64'd1);
            @(negedge clk);
            chk($sformatf("v%0d_done_pulse", k), 64'(bus.done), 64'd0);
        end else begin
            for (int b = 0; b < v.nb; b++) begin
                wait_en(ok);
                if (ok) begin
                    chk($sformatf("v%0d_b%0d_rd", k, b), 64'(bus.ext_read_enable), 64'(!v.wr));
                    chk($sformatf("v%0d_b%0d_wr", k, b), 64'(bus.ext_write_enable), 64'(v.wr));
                    chk($sformatf("v%0d_b%0d_addr", k, b), 64'(bus.ext_addr), 64'(v.ea[b]));
                    chk($sformatf("v%0d_b%0d_len", k, b), 64'(bus.ext_word_size), 64'(v.el[b]));
                    chk($sformatf("v%0d_b%0d_busy", k, b), 64'(bus.busy), 64'd1);
                    @(negedge clk);
                    chk($sformatf("v%0d_b%0d_endrop", k, b),
                        64'({bus.ext_read_enable, bus.ext_write_enable}), 64'd0);
                    chk($sformatf("v%0d_b%0d_done", k, b), 64'(bus.done), 64'(b == v.nb - 1));
                end
            end
            @(negedge clk);
            chk($sformatf("v%0d_after_done", k), 64'(bus.done), 64'd0);
            chk($sformatf("v%0d_after_ready", k), 64'(bus.req_ready), 64'd1);
        end
    endtask

    initial begin
        bit ok;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_size  = '0;
        bus.ext_ready = 1'b1;

        vecs[0] = mk(1'b0, 32'h0000_0000, 32'd16,  1, 32'h0,         9'd16,  32'h0,    9'd0,   32'h0,   9'd0);
        vecs[1] = mk(1'b1, 32'h0000_0000, 32'd600, 3, 32'h0,         9'd256, 32'h400,  9'd256, 32'h800, 9'd88);
        vecs[2] = mk(1'b0, 32'h0000_0FF0, 32'd10,  2, 32'hFF0,       9'd4,   32'h1000, 9'd6,   32'h0,   9'd0);
        vecs[3] = mk(1'b0, 32'h0000_1234, 32'd0,   0, 32'h0,         9'd0,   32'h0,    9'd0,   32'h0,   9'd0);
        vecs[4] = mk(1'b1, 32'h0000_0C00, 32'd300, 2, 32'hC00,       9'd256, 32'h1000, 9'd44,  32'h0,   9'd0);
        vecs[5] = mk(1'b0, 32'h0000_0FF2, 32'd2,   1, 32'hFF0,       9'd2,   32'h0,    9'd0,   32'h0,   9'd0);
        vecs[6] = mk(1'b1, 32'hFFFF_FFF0, 32'd8,   2, 32'hFFFF_FFF0, 9'd4,   32'h0,    9'd4,   32'h0,   9'd0);

        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_en", 64'({bus.ext_read_enable, bus.ext_write_enable}), 64'd0);
        chk("rst_addr", 64'(bus.ext_addr), 64'd0);
        chk("rst_len", 64'(bus.ext_word_size), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 64'(bus.req_ready), 64'd1);

        for (int k = 0; k < 7; k++) run_vec(k);

        // Address channel stalled for five cycles while a second request is presented
        bus.ext_ready = 1'b0;
        @(negedge clk);
        send(1'b0, 32'h0000_0100, 32'd8);
        @(negedge clk);
        send(1'b1, 32'h0000_2000, 32'd4);
        wait_en(ok);
        if (ok) begin
            for (int i = 0; i < 5; i++) begin
                chk($sformatf("stall%0d_rd", i), 64'(bus.ext_read_enable), 64'd1);
                chk($sformatf("stall%0d_wr", i), 64'(bus.ext_write_enable), 64'd0);
                chk($sformatf("stall%0d_addr", i), 64'(bus.ext_addr), 64'h100);
                chk($sformatf("stall%0d_len", i), 64'(bus.ext_word_size), 64'd8);
                chk($sformatf("stall%0d_ready", i), 64'(bus.req_ready), 64'd0);
                if (i == 2) bus.req_valid = 1'b0;
                @(negedge clk);
            end
            chk("stall_hold6", 64'(bus.ext_read_enable), 64'd1);
            bus.ext_ready = 1'b1;
            @(negedge clk);
            chk("stall_drop", 64'(bus.ext_read_enable), 64'd0);
            chk("stall_done", 64'(bus.done), 64'd1);
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                chk($sformatf("ignored%0d_en", i), 64'({bus.ext_read_enable, bus.ext_write_enable}), 64'd0);
                chk($sformatf("ignored%0d_done", i), 64'(bus.done), 64'd0);
            end
        end
        bus.req_valid = 1'b0;
        bus.ext_ready = 1'b1;

        // Reset while a 600-word write is being issued
        bus.ext_ready = 1'b0;
        @(negedge clk);
        send(1'b1, 32'h0, 32'd600);
        @(negedge clk);
        bus.req_valid = 1'b0;
        wait_en(ok);
        chk("abort_wr_before", 64'(bus.ext_write_enable), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_en", 64'({bus.ext_read_enable, bus.ext_write_enable}), 64'd0);
        chk("abort_done", 64'(bus.done), 64'd0);
        chk("abort_busy", 64'(bus.busy), 64'd0);
        rst = 1'b0;
        bus.ext_ready = 1'b1;
        @(negedge clk);
        chk("abort_ready", 64'(bus.req_ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("abort_quiet%0d", i), 64'({bus.done, bus.ext_write_enable}), 64'd0);
            @(negedge clk);
        end

        run_vec(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected completion before 200000 time units");
        $fatal(1);
    end
endmodule

// File: doc/dmac_burst_scheduler.md
DMAC_BURST_SCHEDULER -- requirements
Module: dmac_burst_scheduler

Interface
REQ-001 SHALL have parameter W_D, default 32, data word width in bits (power of two, >= 8).
REQ-002 SHALL have parameter W_EXT_A, default 32, external byte-address width.
REQ-003 SHALL have parameter W_BOUNDARY_A, default 12, AXI burst-boundary exponent (4KB).
REQ-004 SHALL have parameter W_BLEN, default 9, burst-length field width.
REQ-005 SHALL have parameter MAX_BURST_LEN, default 256, maximum words per burst.
REQ-006 SHALL have parameter W_SIZE, default 32, total-transfer word-count width.
REQ-007 SHALL provide ports, clock and reset first:
 CLK  in  1  single clock; all logic rising-edge.
 RST  in  1  synchronous, active-high reset.
 req_valid  in  1  transfer request present.
 req_ready  out  1  scheduler accepts request.
 req_write  in  1  1 = write transfer, 0 = read transfer.
 req_addr  in  W_EXT_A  start byte address.
 req_size  in  W_SIZE  total words.
 busy  out  1  transfer in progress.
 done  out  1  one-cycle pulse at transfer completion.
 ext_addr  out  W_EXT_A  burst byte address.
 ext_read_enable  out  1  read burst request.
 ext_write_enable  out  1  write burst request.
 ext_word_size  out  W_BLEN  burst length in words.
 ext_ready  in  1  address channel accepts burst.

Function
REQ-008 SHALL implement FSM states IDLE, CALC, ISSUE; req_ready = 1 only in IDLE, busy = 1 in CALC and ISSUE.
REQ-009 SHALL accept a request on req_valid && req_ready and latch addr, size and direction; low log2(W_D/8) address bits are forced to zero.
REQ-010 SHALL, on acceptance with req_size != 0, go IDLE -> CALC.
REQ-011 SHALL, on acceptance with req_size == 0, stay in IDLE, issue no burst, and pulse done on the next cycle.
REQ-012 SHALL, in CALC, register burst length = min(remaining, MAX_BURST_LEN, words_to_boundary), then go to ISSUE.
REQ-013 SHALL compute words_to_boundary = (2^W_BOUNDARY_A - (addr mod 2^W_BOUNDARY_A)) / (W_D/8) in W_BOUNDARY_A+1 bits, with no truncation.
REQ-014 SHALL, in ISSUE, assert exactly one of ext_read_enable/ext_write_enable, per latched direction, with ext_addr and ext_word_size driven from registers.
REQ-015 SHALL hold the enable, ext_addr and ext_word_size stable while ext_ready = 0.
REQ-016 SHALL, on enable && ext_ready, advance addr by len*(W_D/8) and subtract len from remaining, deassert the enable on the next cycle, then:
 - go to CALC if remaining != 0;
 - go to IDLE and pulse done (1 cycle) if remaining == 0.
REQ-017 SHALL issue each burst's address-channel handshake exactly once; the minimum gap between bursts is 1 cycle (CALC).
REQ-018 SHALL wrap address arithmetic modulo 2^W_EXT_A.
REQ-019 SHALL ignore req_valid while busy; a request is held by the requester until req_ready.

Reset
REQ-020 SHALL, on RST, go to IDLE and clear ext_read_enable, ext_write_enable, ext_addr, ext_word_size, done, busy and internal counters to 0; req_ready = 1 on the first cycle after RST deasserts.
REQ-021 SHALL abort an in-progress transfer on RST without a done pulse; the enables are low in the cycle following RST assertion.

Structure
REQ-022 SHALL place the FSM state encodings (IDLE=0, CALC=1, ISSUE=2) and the bytes-per-word constant in shared package dmac_pkg.
REQ-023 SHALL isolate the min/boundary computation in combinational sub-module dmac_burst_len_calc (inputs addr, remaining; output len).

Verification (W_D=32, 4KB boundary, MAX_BURST_LEN=256)
REQ-024 SHALL cover: read, addr 0x0000, size 16 -> one burst with ext_read_enable, addr 0x0000, len 16; then done pulse.
REQ-025 SHALL cover: write, addr 0x0000, size 600 -> bursts 256@0x000, 256@0x400, 88@0x800; done after the third handshake.
REQ-026 SHALL cover: read, addr 0x0FF0, size 10 -> bursts 4@0x0FF0, 6@0x1000.
REQ-027 SHALL cover: size 0 -> no enable asserted; done pulse one cycle after acceptance; req_ready stays 1.
REQ-028 SHALL cover: ext_ready held low 5 cycles during a burst -> enable, addr and size stable; handshake on cycle 6; second req_valid during busy is ignored.
REQ-029 SHALL cover: RST asserted during ISSUE of a 600-word transfer -> enables 0 next cycle, no done pulse, req_ready 1 after release.
